// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Shares the single write port of a FIFO between NUM_REQ requesters using
//   round-robin arbitration with a per-grant burst limit. A credit counter
//   tracks free FIFO entries so that no write is ever issued into a full FIFO.
//   The FIFO read side returns credits via rd_pop, already synchronous to clk.
//
// Ports:
//   clk          single clock, all logic on posedge
//   Async_Reset  asynchronous, active-high reset
//   req          per-requester write request, held while data is pending
//   req_data     requester i data on bits [i*DATA_WIDTH +: DATA_WIDTH]
//   grant        registered current owner, one-hot or zero
//   ack          combinational, beat of the owner consumed this cycle
//   Wr_enable    registered FIFO write strobe
//   data_in      registered FIFO write data
//   rd_pop       one-cycle pulse per FIFO read, frees one entry
//   credits      free FIFO entries
//   busy         high while a grant is active (state BURST)
//   credit_err   sticky, rd_pop seen while the FIFO was already empty
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          Async_Reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          Wr_enable,
  output logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          rd_pop,
  output logic [ADDR_WIDTH:0]           credits,
  output logic                          busy,
  output logic                          credit_err
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BEAT_W = $clog2(MAX_BURST + 1);

  localparam logic [IDX_W-1:0]      LAST_REQ   = IDX_W'(NUM_REQ - 1);
  localparam logic [BEAT_W-1:0]     BEAT_LAST  = BEAT_W'(MAX_BURST - 1);
  localparam logic [BEAT_W-1:0]     BEAT_ONE   = BEAT_W'(1);
  localparam logic [ADDR_WIDTH:0]   DEPTH      = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   ONE_CREDIT = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]        last_winner_q, last_winner_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic                    wr_enable_q, wr_enable_d;
  logic [DATA_WIDTH-1:0]   data_in_q, data_in_d;
  logic [ADDR_WIDTH:0]     credits_q, credits_d;
  logic                    credit_err_q, credit_err_d;

  logic                    winner_found;
  logic [IDX_W-1:0]        winner_idx;
  logic                    owner_req;
  logic                    owner_grant;
  logic [DATA_WIDTH-1:0]   owner_data;
  logic                    ack_any;

  // Round-robin search: first look at requesters above the last winner,
  // then wrap around to the ones at or below it.
  always_comb begin
    winner_found = 1'b0;
    winner_idx   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!winner_found && req[j] && (IDX_W'(j) > last_winner_q)) begin
        winner_found = 1'b1;
        winner_idx   = IDX_W'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!winner_found && req[j] && (IDX_W'(j) <= last_winner_q)) begin
        winner_found = 1'b1;
        winner_idx   = IDX_W'(j);
      end
    end
  end

  // The owner of an active grant is always the last winner, so its request,
  // grant bit and data are selected by last_winner_q.
  always_comb begin
    owner_req   = 1'b0;
    owner_grant = 1'b0;
    owner_data  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (IDX_W'(j) == last_winner_q) begin
        owner_req   = req[j];
        owner_grant = grant_q[j];
        owner_data  = req_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A beat is consumed only when the owner still requests and a FIFO entry
  // is known to be free.
  always_comb begin
    ack_any = (state_q == BURST) && owner_grant && owner_req && (credits_q != '0);
    ack     = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (IDX_W'(j) == last_winner_q) begin
        ack[j] = ack_any;
      end
    end
  end

  // Next-state and registered-output logic of the arbitration FSM.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_winner_d = last_winner_q;
    beat_d        = beat_q;
    wr_enable_d   = 1'b0;
    data_in_d     = data_in_q;

    unique case (state_q)
      IDLE: begin
        if (winner_found) begin
          for (int j = 0; j < NUM_REQ; j++) begin
            grant_d[j] = (IDX_W'(j) == winner_idx);
          end
          last_winner_d = winner_idx;
          beat_d        = '0;
          state_d       = BURST;
        end
      end
      BURST: begin
        if (ack_any) begin
          wr_enable_d = 1'b1;
          data_in_d   = owner_data;
          beat_d      = beat_q + BEAT_ONE;
        end
        // Grant ends on the last allowed beat or when the owner withdraws;
        // with no credits and req still high the grant simply stalls.
        if ((ack_any && (beat_q == BEAT_LAST)) || !owner_req) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Credit counter: a simultaneous ack and pop cancel out; a pop with the
  // FIFO already empty is flagged and never pushes credits above depth.
  always_comb begin
    credits_d    = credits_q;
    credit_err_d = credit_err_q;
    if (rd_pop && (credits_q == DEPTH)) begin
      credit_err_d = 1'b1;
    end
    if (ack_any && !rd_pop) begin
      credits_d = credits_q - ONE_CREDIT;
    end else if (rd_pop && !ack_any && (credits_q != DEPTH)) begin
      credits_d = credits_q + ONE_CREDIT;
    end
  end

  // Reset abandons any burst in flight; the credit of an acked beat that
  // never reached the FIFO is restored by the full-depth reset value.
  always_ff @(posedge clk or posedge Async_Reset) begin
    if (Async_Reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      last_winner_q <= LAST_REQ;
      beat_q        <= '0;
      wr_enable_q   <= 1'b0;
      data_in_q     <= '0;
      credits_q     <= DEPTH;
      credit_err_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_winner_q <= last_winner_d;
      beat_q        <= beat_d;
      wr_enable_q   <= wr_enable_d;
      data_in_q     <= data_in_d;
      credits_q     <= credits_d;
      credit_err_q  <= credit_err_d;
    end
  end

  assign grant      = grant_q;
  assign Wr_enable  = wr_enable_q;
  assign data_in    = data_in_q;
  assign credits    = credits_q;
  assign busy       = (state_q == BURST);
  assign credit_err = credit_err_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter
//   Directed bench for fifo_write_arbiter. A default instance (MAX_BURST=4)
//   is driven from a per-cycle vector table plus a mid-burst reset sequence;
//   a second instance with MAX_BURST=2 exercises round-robin rotation.
module tb_fifo_write_arbiter;

  logic        clk;
  logic        async_reset;

  logic [3:0]  req;
  logic [31:0] req_data;
  logic        rd_pop;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic        wr_enable;
  logic [7:0]  data_in;
  logic [2:0]  credits;
  logic        busy;
  logic        credit_err;

  logic [3:0]  req_b;
  logic [31:0] req_data_b;
  logic        rd_pop_b;
  logic [3:0]  grant_b;
  logic [3:0]  ack_b;
  logic        wr_enable_b;
  logic [7:0]  data_in_b;
  logic [2:0]  credits_b;
  logic        busy_b;
  logic        credit_err_b;

  int assertCount;
  int failCount;
  logic [3:0] expGrant;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] rdata;
    logic        pop;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic        wr;
    logic [7:0]  din;
    logic [2:0]  cred;
    logic        busy;
    logic        err;
  } vec_t;

  vec_t vecs [31];

  fifo_write_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(8), .ADDR_WIDTH(2), .MAX_BURST(4)
  ) u_dut (
    .clk(clk), .Async_Reset(async_reset), .req(req), .req_data(req_data),
    .grant(grant), .ack(ack), .Wr_enable(wr_enable), .data_in(data_in),
    .rd_pop(rd_pop), .credits(credits), .busy(busy), .credit_err(credit_err)
  );

  fifo_write_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(8), .ADDR_WIDTH(2), .MAX_BURST(2)
  ) u_dut_b2 (
    .clk(clk), .Async_Reset(async_reset), .req(req_b), .req_data(req_data_b),
    .grant(grant_b), .ack(ack_b), .Wr_enable(wr_enable_b), .data_in(data_in_b),
    .rd_pop(rd_pop_b), .credits(credits_b), .busy(busy_b), .credit_err(credit_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    req      = v.req;
    req_data = v.rdata;
    rd_pop   = v.pop;
  endtask

  // Per row: inputs applied shortly after a rising edge, then outputs of that
  // same cycle (ack combinational, the rest registered) are checked.
  initial begin
    //          req      rdata         pop   grant    ack      wr    din    cred  busy  err
    vecs[0]  = '{4'b0001, 32'h000000A0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 3'd4, 1'b0, 1'b0};
    vecs[1]  = '{4'b0001, 32'h000000A0, 1'b0, 4'b0001, 4'b0001, 1'b0, 8'h00, 3'd4, 1'b1, 1'b0};
    vecs[2]  = '{4'b0001, 32'h000000A1, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'hA0, 3'd3, 1'b1, 1'b0};
    vecs[3]  = '{4'b0001, 32'h000000A2, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'hA1, 3'd2, 1'b1, 1'b0};
    vecs[4]  = '{4'b0001, 32'h000000A3, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'hA2, 3'd1, 1'b1, 1'b0};
    vecs[5]  = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 4'b0000, 1'b1, 8'hA3, 3'd0, 1'b0, 1'b0};
    vecs[6]  = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'hA3, 3'd0, 1'b0, 1'b0};
    vecs[7]  = '{4'b0100, 32'h00C50000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'hA3, 3'd0, 1'b0, 1'b0};
    vecs[8]  = '{4'b0100, 32'h00C50000, 1'b0, 4'b0100, 4'b0000, 1'b0, 8'hA3, 3'd0, 1'b1, 1'b0};
    vecs[9]  = '{4'b0100, 32'h00C50000, 1'b0, 4'b0100, 4'b0000, 1'b0, 8'hA3, 3'd0, 1'b1, 1'b0};
    vecs[10] = '{4'b0100, 32'h00C50000, 1'b1, 4'b0100, 4'b0000, 1'b0, 8'hA3, 3'd0, 1'b1, 1'b0};
    vecs[11] = '{4'b0100, 32'h00C50000, 1'b0, 4'b0100, 4'b0100, 1'b0, 8'hA3, 3'd1, 1'b1, 1'b0};
    vecs[12] = '{4'b0100, 32'h00C60000, 1'b0, 4'b0100, 4'b0000, 1'b1, 8'hC5, 3'd0, 1'b1, 1'b0};
    vecs[13] = '{4'b0000, 32'h00000000, 1'b1, 4'b0100, 4'b0000, 1'b0, 8'hC5, 3'd0, 1'b1, 1'b0};
    vecs[14] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'hC5, 3'd1, 1'b0, 1'b0};
    vecs[15] = '{4'b0100, 32'h00C60000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'hC5, 3'd2, 1'b0, 1'b0};
    vecs[16] = '{4'b0100, 32'h00C60000, 1'b1, 4'b0100, 4'b0100, 1'b0, 8'hC5, 3'd2, 1'b1, 1'b0};
    vecs[17] = '{4'b0000, 32'h00000000, 1'b0, 4'b0100, 4'b0000, 1'b1, 8'hC6, 3'd2, 1'b1, 1'b0};
    vecs[18] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'hC6, 3'd2, 1'b0, 1'b0};
    vecs[19] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'hC6, 3'd3, 1'b0, 1'b0};
    vecs[20] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'hC6, 3'd4, 1'b0, 1'b0};
    vecs[21] = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'hC6, 3'd4, 1'b0, 1'b1};
    vecs[22] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'hC6, 3'd4, 1'b0, 1'b1};
    vecs[23] = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'hC6, 3'd4, 1'b0, 1'b1};
    vecs[24] = '{4'b1001, 32'hD3000000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'hC6, 3'd4, 1'b0, 1'b1};
    vecs[25] = '{4'b1001, 32'hD3000000, 1'b0, 4'b1000, 4'b1000, 1'b0, 8'hC6, 3'd4, 1'b1, 1'b1};
    vecs[26] = '{4'b0001, 32'h00000000, 1'b0, 4'b1000, 4'b0000, 1'b1, 8'hD3, 3'd3, 1'b1, 1'b1};
    vecs[27] = '{4'b0001, 32'h00000000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'hD3, 3'd3, 1'b0, 1'b1};
    vecs[28] = '{4'b0001, 32'h000000E0, 1'b0, 4'b0001, 4'b0001, 1'b0, 8'hD3, 3'd3, 1'b1, 1'b1};
    vecs[29] = '{4'b0000, 32'h00000000, 1'b0, 4'b0001, 4'b0000, 1'b1, 8'hE0, 3'd2, 1'b1, 1'b1};
    vecs[30] = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'hE0, 3'd2, 1'b0, 1'b1};
  end

  initial begin
    assertCount = 0;
    failCount   = 0;
    req         = '0;
    req_data    = '0;
    rd_pop      = 1'b0;
    req_b       = '0;
    req_data_b  = '0;
    rd_pop_b    = 1'b0;
    async_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    async_reset = 1'b0;

    // Reset state
    checkOutput("reset grant", 32'(grant), 32'h0);
    checkOutput("reset wr_enable", 32'(wr_enable), 32'h0);
    checkOutput("reset credits", 32'(credits), 32'h4);
    checkOutput("reset credit_err", 32'(credit_err), 32'h0);

    // Vector table
    for (int i = 0; i < 31; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("row%0d grant", i), 32'(grant), 32'(vecs[i].grant));
      checkOutput($sformatf("row%0d ack", i), 32'(ack), 32'(vecs[i].ack));
      checkOutput($sformatf("row%0d wr_enable", i), 32'(wr_enable), 32'(vecs[i].wr));
      checkOutput($sformatf("row%0d data_in", i), 32'(data_in), 32'(vecs[i].din));
      checkOutput($sformatf("row%0d credits", i), 32'(credits), 32'(vecs[i].cred));
      checkOutput($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].busy));
      checkOutput($sformatf("row%0d credit_err", i), 32'(credit_err), 32'(vecs[i].err));
      @(posedge clk);
      #1;
    end

    // Reset asserted during an ack cycle, before the write strobe
    req      = 4'b0001;
    req_data = 32'h00000055;
    rd_pop   = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst ack before reset", 32'(ack), 32'h1);
    #1;
    async_reset = 1'b1;
    #1;
    checkOutput("midrst grant", 32'(grant), 32'h0);
    checkOutput("midrst wr_enable", 32'(wr_enable), 32'h0);
    checkOutput("midrst busy", 32'(busy), 32'h0);
    checkOutput("midrst credits", 32'(credits), 32'h4);
    checkOutput("midrst credit_err", 32'(credit_err), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("midrst wr_enable held", 32'(wr_enable), 32'h0);
    async_reset = 1'b0;
    req         = 4'b1001;
    req_data    = 32'h77000066;
    @(posedge clk);
    #1;
    checkOutput("postrst grant r0 first", 32'(grant), 32'h1);
    checkOutput("postrst ack", 32'(ack), 32'h1);
    @(posedge clk);
    #1;
    checkOutput("postrst wr_enable", 32'(wr_enable), 32'h1);
    checkOutput("postrst data_in", 32'(data_in), 32'h66);
    checkOutput("postrst credits", 32'(credits), 32'h3);
    req = 4'b0000;

    // Round-robin rotation with MAX_BURST=2, all requesting, pop every cycle
    async_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    async_reset = 1'b0;
    req_b       = 4'b1111;
    req_data_b  = 32'h13121110;
    rd_pop_b    = 1'b1;
    for (int g = 0; g < 5; g++) begin
      checkOutput($sformatf("rr g%0d idle grant", g), 32'(grant_b), 32'h0);
      checkOutput($sformatf("rr g%0d idle ack", g), 32'(ack_b), 32'h0);
      @(posedge clk);
      #1;
      expGrant = 4'b0001 << (g % 4);
      for (int b = 0; b < 2; b++) begin
        checkOutput($sformatf("rr g%0d b%0d grant", g, b), 32'(grant_b), 32'(expGrant));
        checkOutput($sformatf("rr g%0d b%0d ack", g, b), 32'(ack_b), 32'(expGrant));
        checkOutput($sformatf("rr g%0d b%0d credits", g, b), 32'(credits_b), 32'h4);
        if (b == 1) begin
          checkOutput($sformatf("rr g%0d wr_enable", g), 32'(wr_enable_b), 32'h1);
          checkOutput($sformatf("rr g%0d data_in", g), 32'(data_in_b), 32'(16 + (g % 4)));
        end
        @(posedge clk);
        #1;
      end
    end
    req_b    = '0;
    rd_pop_b = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the single write port of the FIFO between NUM_REQ requesters.
- Uses round-robin arbitration with a per-grant burst limit.
- Tracks free FIFO entries with a credit counter, so no write is ever issued into a full FIFO.
- Sits on the FIFO write-clock domain; the FIFO's read side returns credits through a single-cycle pop pulse that is already synchronous to clk.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_WIDTH, 8, FIFO data width.
- ADDR_WIDTH, 2, FIFO address width; FIFO depth = 2**ADDR_WIDTH.
- MAX_BURST, 4, maximum accepted beats per grant (>=1).

Ports:
- clk  input  1  single clock; all logic on posedge.
- Async_Reset  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester write request; held high while data is pending.
- req_data  input  NUM_REQ*DATA_WIDTH  requester i data on bits [i*DATA_WIDTH +: DATA_WIDTH].
- grant  output  NUM_REQ  registered, one-hot or zero; current owner.
- ack  output  NUM_REQ  combinational; beat of requester i consumed this cycle.
- Wr_enable  output  1  registered FIFO write strobe.
- data_in  output  DATA_WIDTH  registered FIFO write data.
- rd_pop  input  1  one-cycle pulse per successful FIFO read (frees one entry).
- credits  output  ADDR_WIDTH+1  free FIFO entries.
- busy  output  1  high in state BURST.
- credit_err  output  1  sticky; rd_pop received while credits == depth.

Behaviour:
- Reset (async, immediate) sets:
  - state = IDLE, grant = 0, Wr_enable = 0, data_in = 0;
  - credits = 2**ADDR_WIDTH, beat count = 0;
  - last_winner = NUM_REQ-1, so requester 0 has first priority;
  - credit_err = 0.
- Reset asserted mid-burst abandons the burst. No write is issued, and the credit for a beat that was in flight is restored by the reset value.
- FSM, state IDLE:
  - If req != 0, the winner is the first requester with req high, searching from last_winner+1 upward modulo NUM_REQ.
  - Next edge: grant <= one-hot(winner), last_winner <= winner, beat <= 0, state <= BURST.
  - Credits do not gate arbitration.
- FSM, state BURST (owner w):
  - ack[w] = grant[w] & req[w] & (credits != 0); all other ack bits are 0.
  - On an ack cycle, at the next edge: Wr_enable <= 1, data_in <= req_data slice w, beat <= beat+1. Otherwise Wr_enable <= 0 and data_in holds its value.
  - Write latency: ack at cycle N means Wr_enable high at cycle N+1.
  - Exit to IDLE (grant <= 0) at the edge where either (ack and beat == MAX_BURST-1) or req[w] == 0.
  - If credits == 0 and req[w] == 1: stall in BURST, grant held, no ack.
- Minimum arbitration gap: one IDLE cycle between consecutive grants. Grant therefore rises one cycle after req is seen in IDLE.
- Credit counter, width ADDR_WIDTH+1, saturating:
  - ack only: -1.
  - rd_pop only: +1.
  - ack and rd_pop in the same cycle: unchanged.
  - rd_pop while credits == 2**ADDR_WIDTH: credits unchanged, credit_err <= 1 (sticky until reset).
  - ack never occurs at credits == 0, so there is no underflow.
- Requester rules:
  - Hold req and data stable until ack.
  - Dropping req without ack is allowed; it ends the grant.
  - Requests from non-owners are ignored until the next IDLE.
- Round-robin wrap: after last_winner = NUM_REQ-1, the search starts at 0.
- Invariants:
  - grant is never multi-hot.
  - At most one Wr_enable per cycle.
  - The number of Wr_enable pulses since reset minus rd_pop pulses never exceeds 2**ADDR_WIDTH.

Test Plan:
- Reset then req=4'b0001 (data 8'hA0..A3 over successive acks), no pops:
  - grant=0001 from cycle 1;
  - four acks, Wr_enable pulses carry A0,A1,A2,A3;
  - credits 4->0;
  - grant drops after 4th ack; busy low.
- req=4'b1111 held, rd_pop pulsed every cycle, MAX_BURST=2:
  - grant sequence 0001, 0010, 0100, 1000, 0001, each for 2 acks separated by one idle cycle;
  - credits stay at 4 ± 1.
- FIFO fill, requester 2 holds req with credits=0:
  - grant=0100 held, ack=0, no Wr_enable;
  - single rd_pop -> credits 1, one ack next cycle, Wr_enable the cycle after.
- ack and rd_pop in the same cycle at credits=2 -> credits stays 2.
- rd_pop at credits=4 -> credits stays 4, credit_err=1 and remains 1 until Async_Reset.
- Async_Reset asserted between ack and Wr_enable mid-burst:
  - grant, Wr_enable and busy go 0 immediately, no write strobe, credits=4;
  - after release, req=4'b1001 -> requester 0 wins first.
